fetch_stage: RTL and testbench

- Program-counter and IF/ID pipeline-register block of the MIPS datapath.
- Drives the byte address into the instruction memory and captures the 32-bit big-endian word that the memory returns combinationally in the same cycle.
- Computes next-PC from sequential, branch, jump and jump-register redirects issued by decode.
- Handles hazard stalls, flushes and address faults, and presents a registered instruction, PC+4 and valid flag to the decoder.

---
 rtl/fetch_stage_pkg.sv | 25 ++
 rtl/fetch_stage_if.sv | 28 ++
 rtl/fetch_stage_next_pc.sv | 44 ++++
 rtl/fetch_stage.sv | 77 +++++++
 tb/tb_fetch_stage.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared MIPS fetch definitions: constants, field widths, next-PC select and FSM encodings.
package fetch_stage_pkg;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   localparam int          IMM_W        = 16;
   localparam int          JIDX_W       = 26;

   typedef enum logic [2:0] {
      SEL_SEQ,
      SEL_STALL,
      SEL_BRANCH,
      SEL_JUMP,
      SEL_JREG
   } pc_sel_e;

   typedef enum logic {
      ST_RUN,
      ST_FAULTED
   } fetch_state_e;

   // 33-bit compare so a target near 2^32 cannot wrap past the size check
   function automatic logic bad_target(input logic [31:0] t, input int unsigned mem_bytes);
      return (t[1:0] != 2'b00) || (({1'b0, t} + 33'd3) >= 33'(mem_bytes));
   endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory address/data, decode redirects and the IF/ID register outputs.
interface fetch_if;
   logic [31:0]                        pc;
   logic [31:0]                        instruction;
   logic                               stall;
   logic                               branch_taken;
   logic [fetch_stage_pkg::IMM_W-1:0]  branch_offset;
   logic                               jump;
   logic [fetch_stage_pkg::JIDX_W-1:0] jump_index;
   logic                               jump_reg;
   logic [31:0]                        reg_target;
   logic [31:0]                        if_instruction;
   logic [31:0]                        if_pc_plus4;
   logic                               if_valid;
   logic                               fault;
   logic [31:0]                        fetch_count;

   modport master (
      output pc, if_instruction, if_pc_plus4, if_valid, fault, fetch_count,
      input  instruction, stall, branch_taken, branch_offset, jump, jump_index,
             jump_reg, reg_target
   );
   modport slave (
      input  pc, if_instruction, if_pc_plus4, if_valid, fault, fetch_count,
      output instruction, stall, branch_taken, branch_offset, jump, jump_index,
             jump_reg, reg_target
   );
endinterface

// File: rtl/fetch_stage_next_pc.sv
// Combinational next-PC selection: picks the winning redirect, forms its target and flags bad targets.
module next_pc_logic
   import fetch_stage_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 4096
) (
   input  logic [31:0]       i_pc,
   input  logic [31:0]       i_if_pc_plus4,
   input  logic              i_if_valid,
   input  logic              i_stall,
   input  logic              i_branch_taken,
   input  logic [IMM_W-1:0]  i_branch_offset,
   input  logic              i_jump,
   input  logic [JIDX_W-1:0] i_jump_index,
   input  logic              i_jump_reg,
   input  logic [31:0]       i_reg_target,
   output logic [31:0]       o_target,
   output pc_sel_e           o_sel,
   output logic              o_bad
);
   logic [31:0] w_br_off;

   assign w_br_off = {{14{i_branch_offset[15]}}, i_branch_offset, 2'b00};

   // Redirects only count when decode holds a real instruction; a bubble never steers.
   always_comb begin
      o_sel    = SEL_SEQ;
      o_target = i_pc + 32'd4;
      if (i_if_valid && i_jump_reg) begin
         o_sel    = SEL_JREG;
         o_target = i_reg_target;
      end else if (i_if_valid && i_jump) begin
         o_sel    = SEL_JUMP;
         o_target = {i_if_pc_plus4[31:28], i_jump_index, 2'b00};
      end else if (i_if_valid && i_branch_taken) begin
         o_sel    = SEL_BRANCH;
         o_target = i_if_pc_plus4 + w_br_off;
      end else if (i_stall) begin
         o_sel    = SEL_STALL;
      end
   end

   assign o_bad = (o_sel != SEL_STALL) && bad_target(o_target, MEM_BYTES);
endmodule

// File: rtl/fetch_stage.sv
// MIPS fetch stage: PC register, IF/ID pipeline register, sticky fault FSM and fetch counter.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
   parameter int unsigned MEM_BYTES = 4096
) (
   input  logic  clk,
   input  logic  reset,
   fetch_if.master bus
);
   logic [31:0]  r_pc, r_if_instr, r_if_pc_plus4, r_count;
   logic         r_if_valid;
   fetch_state_e r_state, w_state_nxt;
   logic [31:0]  w_target;
   pc_sel_e      w_sel;
   logic         w_bad;

   next_pc_logic #(.MEM_BYTES(MEM_BYTES)) u_next_pc (
      .i_pc            (r_pc),
      .i_if_pc_plus4   (r_if_pc_plus4),
      .i_if_valid      (r_if_valid),
      .i_stall         (bus.stall),
      .i_branch_taken  (bus.branch_taken),
      .i_branch_offset (bus.branch_offset),
      .i_jump          (bus.jump),
      .i_jump_index    (bus.jump_index),
      .i_jump_reg      (bus.jump_reg),
      .i_reg_target    (bus.reg_target),
      .o_target        (w_target),
      .o_sel           (w_sel),
      .o_bad           (w_bad)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_RUN;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (r_state == ST_RUN && w_bad) w_state_nxt = ST_FAULTED;
   end

   // A bad target or a redirect leaves a bubble in IF/ID; only sequential fetches count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc          <= RESET_PC;
         r_if_instr    <= NOP_INSTR;
         r_if_pc_plus4 <= '0;
         r_if_valid    <= 1'b0;
         r_count       <= '0;
      end else if (r_state == ST_FAULTED || w_bad) begin
         r_if_instr    <= NOP_INSTR;
         r_if_pc_plus4 <= '0;
         r_if_valid    <= 1'b0;
      end else if (w_sel == SEL_SEQ) begin
         r_pc          <= w_target;
         r_if_instr    <= bus.instruction;
         r_if_pc_plus4 <= r_pc + 32'd4;
         r_if_valid    <= 1'b1;
         if (r_count != '1) r_count <= r_count + 32'd1;
      end else if (w_sel != SEL_STALL) begin
         r_pc          <= w_target;
         r_if_instr    <= NOP_INSTR;
         r_if_pc_plus4 <= '0;
         r_if_valid    <= 1'b0;
      end
   end

   assign bus.pc             = r_pc;
   assign bus.if_instruction = r_if_instr;
   assign bus.if_pc_plus4    = r_if_pc_plus4;
   assign bus.if_valid       = r_if_valid;
   assign bus.fault          = (r_state == ST_FAULTED);
   assign bus.fetch_count    = r_count;
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: driver steps a behavioural model, monitor compares every edge.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   localparam logic [31:0] RPC  = 32'h0000_0000;
   localparam int          MEMB = 4096;

   typedef struct {
      logic [31:0] pc, ir, p4, cnt;
      logic        v, f;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   fetch_if bus();

   fetch_stage #(.RESET_PC(RPC), .MEM_BYTES(MEMB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   logic [31:0] imem [0:1023];
   assign bus.instruction = imem[bus.pc[11:2]];

   exp_t        q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] m_pc, m_ir, m_p4, m_cnt;
   logic        m_v, m_f;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic push();
      exp_t e;
      e.pc = m_pc; e.ir = m_ir; e.p4 = m_p4; e.cnt = m_cnt; e.v = m_v; e.f = m_f;
      q.push_back(e);
   endtask

   task automatic m_reset();
      m_pc = RPC; m_ir = 32'h0; m_p4 = 32'h0; m_cnt = 32'h0; m_v = 1'b0; m_f = 1'b0;
   endtask

   task automatic m_bubble();
      m_v = 1'b0; m_ir = 32'h0; m_p4 = 32'h0;
   endtask

   // Reference: the spec's priority list evaluated directly on architectural values.
   task automatic m_step(input logic st, input logic br, input logic [15:0] off,
                         input logic j, input logic [25:0] ji, input logic jr,
                         input logic [31:0] rt);
      logic [31:0] t;
      longint      lt;
      bit          redir;
      if (m_f) begin
         m_bubble();
         return;
      end
      redir = m_v && (jr || j || br);
      if (!redir && st) return;
      if (m_v && jr)      t = rt;
      else if (m_v && j)  t = (m_p4 & 32'hF000_0000) | (32'(ji) * 32'd4);
      else if (m_v && br) t = m_p4 + 32'($signed(off)) * 32'd4;
      else                t = m_pc + 32'd4;
      lt = 0;
      lt[31:0] = t;
      if ((t % 4) != 0 || lt + 3 >= MEMB) begin
         m_f = 1'b1;
         m_bubble();
      end else if (redir) begin
         m_pc = t;
         m_bubble();
      end else begin
         m_ir = imem[m_pc / 4];
         m_p4 = m_pc + 32'd4;
         m_v  = 1'b1;
         m_pc = t;
         if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end
   endtask

   task automatic step(input logic st, input logic br, input logic [15:0] off,
                       input logic j, input logic [25:0] ji, input logic jr,
                       input logic [31:0] rt);
      @(negedge clk);
      reset = 1'b0;
      bus.stall = st; bus.branch_taken = br; bus.branch_offset = off;
      bus.jump = j; bus.jump_index = ji; bus.jump_reg = jr; bus.reg_target = rt;
      m_step(st, br, off, j, ji, jr, rt);
      push();
   endtask

   task automatic seq();
      step(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
   endtask

   // Reset lands between edges; one entry for the reset itself, one for the edge it spans.
   task automatic async_reset();
      if ($time != 0) @(negedge clk);
      #2;
      m_reset();
      push();
      reset = 1'b1;
      push();
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk or posedge reset);
         #1;
         if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard: got empty queue expected an entry at %0t", $time);
         end else begin
            e = q.pop_front();
            chk("pc", bus.pc, e.pc);
            chk("if_instruction", bus.if_instruction, e.ir);
            chk("if_pc_plus4", bus.if_pc_plus4, e.p4);
            chk("if_valid", 32'(bus.if_valid), 32'(e.v));
            chk("fault", 32'(bus.fault), 32'(e.f));
            chk("fetch_count", bus.fetch_count, e.cnt);
         end
      end
   end

   initial begin
      logic [15:0] off;
      logic [31:0] rt;
      int          k;
      for (int i = 0; i < 1024; i++) imem[i] = $urandom;
      imem[0] = 32'h2008_0005;
      imem[1] = 32'h2009_0003;
      imem[2] = 32'h0109_5020;
      bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_offset = '0;
      bus.jump = 1'b0; bus.jump_index = '0; bus.jump_reg = 1'b0; bus.reg_target = '0;
      async_reset();

      seq(); seq();
      step(1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
      seq(); seq();
      step(1'b0, 1'b1, 16'hFFFE, 1'b0, 26'h0, 1'b0, 32'h0);
      seq(); seq();
      step(1'b0, 1'b0, 16'h0, 1'b1, 26'h40, 1'b0, 32'h0);
      seq();
      step(1'b1, 1'b1, 16'h0003, 1'b1, 26'h5, 1'b1, 32'h40);
      seq();
      step(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h42);
      step(1'b0, 1'b1, 16'h0001, 1'b1, 26'h3, 1'b1, 32'h80);
      seq(); seq();
      async_reset();
      seq();
      step(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'hFFC);
      seq(); seq();
      async_reset();
      seq();
      step(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h1000);
      seq();
      async_reset();

      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(0, 39) == 0) begin
            async_reset();
         end else begin
            off = ($urandom_range(0, 1) == 0) ? 16'($signed($urandom_range(0, 40)) - 20)
                                               : 16'($urandom);
            k = $urandom_range(0, 3);
            rt = (k == 0) ? {20'h0, 10'($urandom), 2'b00} :
                 (k == 1) ? $urandom :
                 (k == 2) ? 32'hFFC : 32'h1000;
            step($urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, off,
                 $urandom_range(0, 9) == 0, 26'($urandom_range(0, 1023)),
                 $urandom_range(0, 9) == 0, rt);
         end
      end

      @(posedge clk);
      #3;
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
